// File: rtl/openram_testchip_pkg.sv
// Shared widths, packet field offsets and FSM encodings for the GPIO packet path.
// PARITY_CHECK_EN adds the RX parity state.
package openram_testchip_pkg;

    localparam int unsigned PacketWidth = 86;
    localparam int unsigned ResultWidth = 64;
    localparam int unsigned CntWidth    = 7;

    // SRAM select field of an incoming packet
    localparam int unsigned SramSelMsb = 85;
    localparam int unsigned SramSelLsb = 83;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {RxIdle, RxShift, RxParity} rx_state_e;
`else
    typedef enum logic [1:0] {RxIdle, RxShift} rx_state_e;
`endif

    typedef enum logic [1:0] {TxIdle, TxStart, TxShift} tx_state_e;

endpackage

// File: rtl/openram_gpio_packet_shifter_if.sv
// Bundles the serial pins and the controller-side packet/result signals of the shifter.
interface openram_gpio_packet_shifter_if #(
    parameter int unsigned PACKET_WIDTH = openram_testchip_pkg::PacketWidth,
    parameter int unsigned RESULT_WIDTH = openram_testchip_pkg::ResultWidth
) ();

    logic                    gpio_in;
    logic [PACKET_WIDTH-1:0] packet_out;
    logic                    packet_valid;
    logic                    rx_busy;
    logic [RESULT_WIDTH-1:0] result_in;
    logic                    result_valid;
    logic                    gpio_out;
    logic                    tx_busy;
    logic                    parity_error;

    modport master (
        output gpio_in,
        output result_in,
        output result_valid,
        input  packet_out,
        input  packet_valid,
        input  rx_busy,
        input  gpio_out,
        input  tx_busy,
        input  parity_error
    );

    modport slave (
        input  gpio_in,
        input  result_in,
        input  result_valid,
        output packet_out,
        output packet_valid,
        output rx_busy,
        output gpio_out,
        output tx_busy,
        output parity_error
    );

endinterface

// File: rtl/gpio_result_serializer.sv
// Serializes a latched result word onto a GPIO pin: one start bit, then the word MSB first.
module gpio_result_serializer
    import openram_testchip_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH = ResultWidth,
    parameter int unsigned CNT_WIDTH    = CntWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [RESULT_WIDTH-1:0] result_i,
    input  logic                    result_valid_i,
    output logic                    gpio_o,
    output logic                    tx_busy_o
);

    tx_state_e               state_q, state_d;
    logic [RESULT_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    last_bit;

    assign last_bit = (cnt_q == CNT_WIDTH'(RESULT_WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TxIdle:  if (result_valid_i) state_d = TxStart;
            TxStart: state_d = TxShift;
            TxShift: if (last_bit) state_d = TxIdle;
            default: state_d = TxIdle;
        endcase
    end

    // Requests arriving outside TxIdle are dropped, not queued.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        gpio_o    = 1'b0;
        tx_busy_o = 1'b1;
        unique case (state_q)
            TxIdle: begin
                tx_busy_o = 1'b0;
                cnt_d     = '0;
                if (result_valid_i) sr_d = result_i;
            end
            TxStart: gpio_o = 1'b1;
            TxShift: begin
                gpio_o = sr_q[RESULT_WIDTH-1];
                sr_d   = {sr_q[RESULT_WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
            end
            default: tx_busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/openram_gpio_packet_shifter.sv
// GPIO serial front end: RX deserializes start-bit framed packets, TX sub-module sends results.
// Define PARITY_CHECK_EN to expect and check an even-parity bit after each RX payload.
module openram_gpio_packet_shifter
    import openram_testchip_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = PacketWidth,
    parameter int unsigned RESULT_WIDTH = ResultWidth,
    parameter int unsigned CNT_WIDTH    = CntWidth
) (
    input  logic                          gpio_clock,
    input  logic                          reset,
    openram_gpio_packet_shifter_if.slave  bus
);

    rx_state_e               rx_state_q, rx_state_d;
    logic [CNT_WIDTH-1:0]    rx_cnt_q, rx_cnt_d;
    logic [PACKET_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic                    valid_q, valid_d;
    logic                    rx_busy;
    logic                    last_bit;

    assign last_bit = (rx_cnt_q == CNT_WIDTH'(PACKET_WIDTH - 1));

    always_ff @(posedge gpio_clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RxIdle: if (bus.gpio_in) rx_state_d = RxShift;
`ifdef PARITY_CHECK_EN
            RxShift:  if (last_bit) rx_state_d = RxParity;
            RxParity: rx_state_d = RxIdle;
`else
            RxShift:  if (last_bit) rx_state_d = RxIdle;
`endif
            default: rx_state_d = RxIdle;
        endcase
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;
`endif

    // packet_out only moves on commit, so the controller never sees a partial frame.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        packet_d   = packet_q;
        valid_d    = 1'b0;
        rx_busy    = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d     = 1'b0;
`endif
        unique case (rx_state_q)
            RxIdle: begin
                rx_busy  = 1'b0;
                rx_cnt_d = '0;
            end
            RxShift: begin
                rx_shift_d = {rx_shift_q[PACKET_WIDTH-2:0], bus.gpio_in};
                rx_cnt_d   = rx_cnt_q + 1'b1;
`ifndef PARITY_CHECK_EN
                if (last_bit) begin
                    packet_d = rx_shift_d;
                    valid_d  = 1'b1;
                end
`endif
            end
`ifdef PARITY_CHECK_EN
            RxParity: begin
                // Even parity: payload XOR parity bit must be zero.
                if ((^rx_shift_q) == bus.gpio_in) begin
                    packet_d = rx_shift_q;
                    valid_d  = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
`endif
            default: rx_busy = 1'b0;
        endcase
    end

    always_ff @(posedge gpio_clock or posedge reset) begin
        if (reset) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            packet_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            packet_q   <= packet_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge gpio_clock or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign bus.parity_error = perr_q;
`else
    assign bus.parity_error = 1'b0;
`endif

    assign bus.packet_out   = packet_q;
    assign bus.packet_valid = valid_q;
    assign bus.rx_busy      = rx_busy;

    gpio_result_serializer #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_tx (
        .clk_i         (gpio_clock),
        .rst_i         (reset),
        .result_i      (bus.result_in),
        .result_valid_i(bus.result_valid),
        .gpio_o        (bus.gpio_out),
        .tx_busy_o     (bus.tx_busy)
    );

endmodule

// File: tb/tb_openram_gpio_packet_shifter.sv
// Self-checking bench for openram_gpio_packet_shifter; RX strobes are scored against a queue.
// Compile with PARITY_CHECK_EN to exercise the parity build.
module tb_openram_gpio_packet_shifter;

    localparam int PW = 86;
    localparam int RW = 64;
`ifdef PARITY_CHECK_EN
    localparam int FrameBits = PW + 1;
`else
    localparam int FrameBits = PW;
`endif
    localparam int ValidLat = FrameBits + 1;

    localparam logic [PW-1:0] Pkt1 = {3'd0, 28'd0, 1'b0, 1'b0, 4'd15, 8'd1, 32'd1, 1'b0, 8'd0};
    localparam logic [PW-1:0] Pkt2 = {3'd5, 1'b0, 1'b1, 8'd0, 9'd5, 64'd0};

    typedef struct {
        logic [PW-1:0] pkt;
        int            cyc;
        bit            perr;
    } exp_t;

    logic gpio_clock;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    exp_t exp_q[$];
    logic [PW-1:0] last_pkt;

    openram_gpio_packet_shifter_if bus_if ();

    openram_gpio_packet_shifter dut (
        .gpio_clock(gpio_clock),
        .reset     (reset),
        .bus       (bus_if)
    );

    initial begin
        gpio_clock = 1'b0;
        forever #5 gpio_clock = ~gpio_clock;
    end

    initial cyc = 0;
    always @(posedge gpio_clock) cyc <= cyc + 1;

    // Scoreboard: every valid/parity strobe must match the oldest expected frame.
    always @(negedge gpio_clock) begin
        exp_t e;
        if (reset) begin
            last_pkt = '0;
        end else if (bus_if.packet_valid || bus_if.parity_error) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: cycle %0d valid=%b perr=%b required no strobe",
                         cyc, bus_if.packet_valid, bus_if.parity_error);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL strobe_cycle: got %0d required %0d", cyc, e.cyc);
                end
                total++;
                if (bus_if.parity_error !== e.perr || bus_if.packet_valid !== !e.perr) begin
                    bad++;
                    $display("FAIL strobe_kind: valid=%b perr=%b required perr=%b",
                             bus_if.packet_valid, bus_if.parity_error, e.perr);
                end
                total++;
                if (bus_if.packet_out !== (e.perr ? last_pkt : e.pkt)) begin
                    bad++;
                    $display("FAIL strobe_packet: got %h required %h", bus_if.packet_out,
                             e.perr ? last_pkt : e.pkt);
                end
                if (!e.perr) last_pkt = e.pkt;
            end
        end else begin
            total++;
            if (bus_if.packet_out !== last_pkt) begin
                bad++;
                $display("FAIL packet_hold: cycle %0d got %h required %h", cyc,
                         bus_if.packet_out, last_pkt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge gpio_clock);
            bus_if.gpio_in = 1'b0;
        end
    endtask

    // Drives start bit, payload MSB first and (parity build) the parity bit; no trailing idle.
    task automatic send_frame(input logic [PW-1:0] pkt, input bit flip, input bit commit);
        exp_t e;
        @(negedge gpio_clock);
        bus_if.gpio_in = 1'b1;
        if (commit) begin
            e.pkt  = pkt;
            e.cyc  = cyc + ValidLat;
            e.perr = flip;
            exp_q.push_back(e);
        end
        for (int i = PW - 1; i >= 0; i--) begin
            @(negedge gpio_clock);
            bus_if.gpio_in = pkt[i];
        end
`ifdef PARITY_CHECK_EN
        @(negedge gpio_clock);
        bus_if.gpio_in = (^pkt) ^ flip;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.gpio_in = 1'b0;
        bus_if.result_valid = 1'b0;
        bus_if.result_in = '0;
        repeat (3) @(negedge gpio_clock);
        total += 6;
        if (bus_if.packet_out !== '0) begin
            bad++; $display("FAIL reset_packet: got %h required 0", bus_if.packet_out);
        end
        if (bus_if.packet_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b required 0", bus_if.packet_valid);
        end
        if (bus_if.rx_busy !== 1'b0) begin
            bad++; $display("FAIL reset_rx_busy: got %b required 0", bus_if.rx_busy);
        end
        if (bus_if.gpio_out !== 1'b0) begin
            bad++; $display("FAIL reset_gpio_out: got %b required 0", bus_if.gpio_out);
        end
        if (bus_if.tx_busy !== 1'b0) begin
            bad++; $display("FAIL reset_tx_busy: got %b required 0", bus_if.tx_busy);
        end
        if (bus_if.parity_error !== 1'b0) begin
            bad++; $display("FAIL reset_perr: got %b required 0", bus_if.parity_error);
        end
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge gpio_clock);
            total++;
            if (bus_if.packet_valid !== 1'b0 || bus_if.gpio_out !== 1'b0 ||
                bus_if.rx_busy !== 1'b0 || bus_if.tx_busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet: cycle %0d valid=%b gpio_out=%b rx_busy=%b tx_busy=%b required all 0",
                         k, bus_if.packet_valid, bus_if.gpio_out, bus_if.rx_busy, bus_if.tx_busy);
            end
        end
    endtask

    task automatic test_single_frame();
        exp_t e;
        logic [PW-1:0] pkt;
        pkt = Pkt1;
        @(negedge gpio_clock);
        bus_if.gpio_in = 1'b1;
        e.pkt = pkt; e.cyc = cyc + ValidLat; e.perr = 1'b0;
        exp_q.push_back(e);
        for (int k = 1; k <= ValidLat + 2; k++) begin
            @(negedge gpio_clock);
            total += 2;
            if (bus_if.rx_busy !== (k <= FrameBits)) begin
                bad++;
                $display("FAIL frame_rx_busy: cycle %0d got %b required %b", k, bus_if.rx_busy,
                         k <= FrameBits);
            end
            if (bus_if.packet_valid !== (k == ValidLat)) begin
                bad++;
                $display("FAIL frame_valid: cycle %0d got %b required %b", k,
                         bus_if.packet_valid, k == ValidLat);
            end
            if (k <= PW) bus_if.gpio_in = pkt[PW-k];
`ifdef PARITY_CHECK_EN
            else if (k == PW + 1) bus_if.gpio_in = ^pkt;
`endif
            else bus_if.gpio_in = 1'b0;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL frame_drain: %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        send_frame(Pkt1, 1'b0, 1'b1);
        send_frame(Pkt2, 1'b0, 1'b1);
        idle(ValidLat + 3);
        total += 2;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_drain: %0d pending required 0", exp_q.size());
        end
        if (bus_if.packet_out !== Pkt2) begin
            bad++; $display("FAIL b2b_packet: got %h required %h", bus_if.packet_out, Pkt2);
        end
    endtask

    task automatic test_reset_abort();
        logic [PW-1:0] pkt;
        pkt = Pkt2;
        @(negedge gpio_clock);
        bus_if.gpio_in = 1'b1;
        for (int k = 1; k < 40; k++) begin
            @(negedge gpio_clock);
            bus_if.gpio_in = pkt[PW-k];
        end
        @(negedge gpio_clock);
        reset = 1'b1;
        #1;
        total += 2;
        if (bus_if.packet_out !== '0) begin
            bad++; $display("FAIL abort_packet: got %h required 0", bus_if.packet_out);
        end
        if (bus_if.rx_busy !== 1'b0) begin
            bad++; $display("FAIL abort_rx_busy: got %b required 0", bus_if.rx_busy);
        end
        @(negedge gpio_clock);
        reset = 1'b0;
        bus_if.gpio_in = 1'b0;
        idle(2);
        send_frame(Pkt1, 1'b0, 1'b1);
        idle(ValidLat + 3);
        total += 2;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL abort_drain: %0d pending required 0", exp_q.size());
        end
        if (bus_if.packet_out !== Pkt1) begin
            bad++; $display("FAIL abort_packet_new: got %h required %h", bus_if.packet_out, Pkt1);
        end
    endtask

    // TX model: a queue of expected pin values, filled only when the model is idle.
    task automatic test_tx();
        bit            txq[$];
        bit            exp_bit;
        bit            was_idle;
        logic [RW-1:0] val;
        fork
            begin
                send_frame(Pkt2, 1'b0, 1'b1);
                idle(1);
            end
        join_none
        for (int k = 0; k <= 140; k++) begin
            @(negedge gpio_clock);
            was_idle = (txq.size() == 0);
            exp_bit  = was_idle ? 1'b0 : txq[0];
            total += 2;
            if (bus_if.gpio_out !== exp_bit) begin
                bad++; $display("FAIL tx_gpio_out: cycle %0d got %b required %b", k,
                                bus_if.gpio_out, exp_bit);
            end
            if (bus_if.tx_busy !== !was_idle) begin
                bad++; $display("FAIL tx_busy: cycle %0d got %b required %b", k,
                                bus_if.tx_busy, !was_idle);
            end
            if (!was_idle) void'(txq.pop_front());
            if (k == 0 || k == 10 || k == 66) begin
                val = (k == 0) ? 64'd5 : (k == 10) ? 64'hFFFF : 64'hA5A5_0F0F_1234_8001;
                bus_if.result_in    = val;
                bus_if.result_valid = 1'b1;
                if (was_idle) begin
                    txq.push_back(1'b1);
                    for (int i = RW - 1; i >= 0; i--) txq.push_back(val[i]);
                end
            end else begin
                bus_if.result_in    = {$urandom, $urandom};
                bus_if.result_valid = 1'b0;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL concurrent_rx_drain: %0d pending required 0", exp_q.size());
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        send_frame(Pkt1, 1'b0, 1'b1);
        idle(3);
        send_frame(Pkt2, 1'b1, 1'b1);
        idle(ValidLat + 3);
        total += 2;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL parity_drain: %0d pending required 0", exp_q.size());
        end
        if (bus_if.packet_out !== Pkt1) begin
            bad++; $display("FAIL parity_hold: got %h required %h", bus_if.packet_out, Pkt1);
        end
    endtask
`else
    task automatic test_parity();
        for (int k = 0; k < 20; k++) begin
            @(negedge gpio_clock);
            total++;
            if (bus_if.parity_error !== 1'b0) begin
                bad++; $display("FAIL parity_tied: got %b required 0", bus_if.parity_error);
            end
        end
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        last_pkt = '0;
        reset    = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_abort();
        test_tx();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/openram_gpio_packet_shifter.md
Name: openram_gpio_packet_shifter

Overview:
Serial front end for the testchip's GPIO path. It deserializes packets arriving one bit per clock on a GPIO pin into a parallel packet word and presents it with a one-cycle valid strobe to the testchip controller's gpio_packet input. In the other direction it serializes the controller's 64-bit read result back out on a GPIO pin. RX and TX run independently on the same clock.

Parameters:
PACKET_WIDTH, 86, payload bits per incoming frame (matches the LA packet format)
RESULT_WIDTH, 64, bits per outgoing result frame
CNT_WIDTH, 7, bit-counter width; must satisfy 2**CNT_WIDTH > max(PACKET_WIDTH, RESULT_WIDTH)

Ports:
gpio_clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high
gpio_in  input  1  serial frame input; idle level 0
packet_out  output  PACKET_WIDTH  last accepted packet, held until the next accepted packet
packet_valid  output  1  one-cycle strobe, packet_out newly updated
rx_busy  output  1  frame reception in progress
result_in  input  RESULT_WIDTH  read data from the controller
result_valid  input  1  load result_in for transmission
gpio_out  output  1  serial result output; idle level 0
tx_busy  output  1  transmission in progress; result_valid ignored while high
parity_error  output  1  one-cycle strobe (PARITY_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset values: packet_out=0, packet_valid=0, rx_busy=0, gpio_out=0, tx_busy=0, parity_error=0. RX and TX FSMs go to IDLE. Counters clear.
- Reset asserted mid-frame aborts the frame. No valid strobe is issued, and packet_out returns to 0.
- RX FSM states: IDLE, SHIFT, PARITY (PARITY state present only with PARITY_CHECK_EN).
- RX IDLE: gpio_in sampled 1 = start bit -> SHIFT, counter=0, rx_busy=1 from the next cycle.
- RX SHIFT: one payload bit is shifted in per cycle, MSB first, into an internal shift register. packet_out is not disturbed during the frame.
- RX SHIFT exit: after PACKET_WIDTH bits -> IDLE, or -> PARITY when the macro is defined.
- RX commit: on the cycle after the last payload bit, packet_out <= shift register and packet_valid=1 for exactly one cycle; rx_busy=0 in that cycle.
- RX timing: start bit at cycle 0, payload at cycles 1..86, valid at cycle 87.
- RX back-to-back: the FSM is in IDLE during the valid cycle, so a start bit in that cycle is accepted. Gaps of any length of 0s are legal.
- TX FSM states: IDLE, START, SHIFT.
- TX IDLE: result_valid=1 latches result_in -> START. tx_busy=1 from the next cycle.
- TX START: gpio_out=1 for one cycle -> SHIFT.
- TX SHIFT: gpio_out drives one bit per cycle, MSB first. After RESULT_WIDTH bits -> IDLE, gpio_out=0, tx_busy=0.
- TX timing: a frame occupies 1+RESULT_WIDTH cycles.
- TX busy rule: result_valid while tx_busy=1 is dropped, with no queuing.
- TX restart: result_valid in the first IDLE cycle after a frame starts a new frame immediately.
- Simultaneous RX and TX activity is fully independent. RX and TX share no state.

Optional Feature:
PARITY_CHECK_EN
- With the macro: one even-parity bit follows the payload; the XOR of payload and parity must be 0. The parity bit is sampled in PARITY.
- Parity match: commit and valid strobe one cycle later than without the macro (valid at cycle 88).
- Parity mismatch: packet_out is unchanged, packet_valid stays 0, and parity_error pulses for one cycle at the would-be valid cycle.
- Without the macro: no parity bit and no PARITY state; parity_error is constant 0.

Decomposition:
- Shared package openram_testchip_pkg holds the packet and result widths (86, 64), the RX/TX state encodings, and the field offsets of the packet (sram select in bits [85:83]).
- The TX half is natural as a sub-module, gpio_result_serializer (result_in, result_valid, gpio_out, tx_busy). The top module holds the RX FSM and instantiates it.

Test Plan:
- Reset then idle 0s for 200 cycles -> packet_valid never asserts, gpio_out=0, all busy flags 0.
- Start bit plus packet {3'd0,28'd0,1'b0,1'b0,4'd15,8'd1,32'd1,1'b0,8'd0}, MSB first -> packet_valid for 1 cycle at cycle 87, packet_out equals that value, rx_busy high during cycles 1..86.
- Two frames back-to-back, second start bit in the valid cycle; second packet {3'd5,1'b0,1'b1,8'd0,9'd5,64'd0} -> two valid strobes 87 cycles apart, packet_out updates to the second value.
- result_valid with result_in=64'd5, plus a second result_valid with 64'hFFFF 10 cycles later -> gpio_out shows start bit, then 5 MSB first over 64 cycles; the second request is ignored; tx_busy high for 65 cycles.
- Reset asserted at cycle 40 of an RX frame, then a full valid frame sent -> no strobe for the aborted frame, correct strobe and packet for the new one.
- With PARITY_CHECK_EN, one frame with correct parity then one with flipped parity -> first gives packet_valid at cycle 88; second gives parity_error only, with packet_out still holding the first packet.
